fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and issues single-word reads to instruction memory over a req/ack handshake. Presents each fetched 16-bit word and its address to the decoder with a valid/ready handshake. Accepts PC redirects from the jump/branch logic and discards any in-flight fetch made stale by a redirect.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `mem_req` output 1: instruction read request; held high until `mem_ack`.
- `mem_addr` output 16: word address of the outstanding request; stable while `mem_req` is high.
- `mem_ack` input 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 16: instruction word from memory.
- `instr` output 16: fetched instruction to the decoder.
- `instr_pc` output 16: address `instr` was fetched from.
- `instr_valid` output 1: `instr`/`instr_pc` are valid.
- `instr_ready` input 1: decoder consumes `instr` this cycle when `instr_valid` is also high.
- `redirect` input 1: taken jump/branch; the new PC is `redirect_pc`.
- `redirect_pc` input 16: redirect target.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: drives `mem_addr`.
  - `instr`, `instr_pc`.
  - FSM state: IDLE, FETCH, HOLD, FLUSH.
- Reset (`reset`==0 at an edge):
  - state=IDLE, `pc`=`RESET_PC`.
  - `mem_req`=0, `mem_addr`=0.
  - `instr`=16'h0000 (NOP), `instr_pc`=0, `instr_valid`=0.
  - Reset asserted mid-operation abandons any outstanding request; memory must tolerate a dropped req.
- IDLE: `req_addr`<=`pc`; go to FETCH next cycle.
- FETCH: `mem_req`=1, `mem_addr`=`req_addr`.
  - On `mem_ack`: `instr`<=`mem_rdata`, `instr_pc`<=`req_addr`, `pc`<=`req_addr`+1; go to HOLD.
- HOLD: `instr_valid`=1; `instr` and `instr_pc` are held stable.
  - On `instr_ready`: `req_addr`<=`pc`; go to FETCH.
- FLUSH: keep `mem_req`=1 at the old `req_addr` until `mem_ack`; discard the data. Then `req_addr`<=`pc`; go to FETCH.
- Redirect has the highest priority in every state except IDLE:
  - HOLD: drop the held instruction (`instr_ready` ignored), `pc`<=`redirect_pc`, `req_addr`<=`redirect_pc`; go to FETCH.
  - FETCH with `mem_ack` in the same cycle: discard the data, `pc`/`req_addr`<=`redirect_pc`; stay in FETCH.
  - FETCH without `mem_ack`: `pc`<=`redirect_pc`; go to FLUSH (the address is not changed mid-request).
  - FLUSH: `pc`<=`redirect_pc` (the latest redirect wins); stay in FLUSH.
  - IDLE: `pc`<=`redirect_pc`.
- Arithmetic: `pc`+1 is 16-bit modulo; 16'hFFFF wraps to 16'h0000.

## Timing
- `instr_valid` is registered. All other outputs are registered except `mem_req`, which is decoded from the state.
- Fetch latency: with zero-wait memory (`mem_ack` in the request cycle), `instr_valid` rises the cycle after FETCH.
- Sustained throughput without the prefetch buffer: one instruction per 2 cycles at zero wait; N-wait memory adds N cycles.
- After a redirect, the first valid target instruction appears 2 cycles later (zero-wait, no flush), or 2 cycles after the stale ack when flushing.
- Deassertion of `reset` to first `mem_req`: 1 cycle (IDLE).

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - Adds a one-entry prefetch buffer.
  - In HOLD, the unit also fetches `pc` into the buffer.
  - On `instr_ready`, a full buffer moves into `instr`/`instr_pc` in the same edge and `instr_valid` stays high. This gives one instruction per cycle at zero wait.
  - Redirect clears the buffer. A buffer fetch still pending at redirect goes through FLUSH.
- Not defined: no buffer; behaviour exactly as in Operation.

## Test plan
- Reset release with `RESET_PC`=16'h0000, zero-wait memory returning addr^16'hA5A5, `instr_ready`=1:
  - First `mem_req` 1 cycle after release, `mem_addr`=0.
  - Decoder sees `instr_pc` 0,1,2 with `instr` 16'hA5A5, 16'hA5A4, 16'hA5A7, one every 2 cycles.
- Backpressure: hold `instr_ready`=0 for 5 cycles in HOLD.
  - `instr`/`instr_pc` are stable and `mem_req`=0 throughout.
  - On release, the next `mem_addr`=`instr_pc`+1.
- 3-wait memory at `pc`=16'h0010:
  - `mem_req` held 4 cycles with `mem_addr`=16'h0010.
  - `instr_valid` rises the cycle after `mem_ack`.
- Redirect to 16'h0200 during a 3-wait fetch of 16'h0010:
  - The stale ack data is discarded; `instr_valid` stays 0.
  - The next `mem_addr`=16'h0200, then `instr_pc`=16'h0200.
- Redirect to 16'h0040 together with `instr_ready` in HOLD:
  - The held word is not re-presented.
  - The next `mem_addr`=16'h0040.
- Wrap: `RESET_PC`=16'hFFFF gives fetches at 16'hFFFF then 16'h0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack, hands words to the decoder.
// Optional one-entry prefetch buffer is enabled by defining FETCH_PREFETCH_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] pc_r;
    logic [15:0] pc_nxt_s;
    logic [15:0] req_addr_r;
    logic [15:0] req_addr_nxt_s;
    logic [15:0] instr_r;
    logic [15:0] instr_nxt_s;
    logic [15:0] instr_pc_r;
    logic [15:0] instr_pc_nxt_s;
    logic        instr_valid_r;
    logic        instr_valid_nxt_s;
    logic        mem_req_s;
    logic        accept_s;

`ifdef FETCH_PREFETCH_EN
    logic        buf_valid_r;
    logic        buf_valid_nxt_s;
    logic [15:0] buf_data_r;
    logic [15:0] buf_data_nxt_s;
    logic [15:0] buf_pc_r;
    logic [15:0] buf_pc_nxt_s;
`endif

    function automatic logic [15:0] inc16(input logic [15:0] a);
        return a + 16'd1;
    endfunction

    // Request strobe decoded from state (and buffer occupancy when prefetching).
    always_comb begin
        mem_req_s = 1'b0;
        case (state_r)
            ST_FETCH: mem_req_s = 1'b1;
            ST_FLUSH: mem_req_s = 1'b1;
`ifdef FETCH_PREFETCH_EN
            ST_HOLD:  mem_req_s = ~buf_valid_r;
`else
            ST_HOLD:  mem_req_s = 1'b0;
`endif
            default:  mem_req_s = 1'b0;
        endcase
    end

    assign accept_s    = mem_req_s & mem_ack;
    assign mem_req     = mem_req_s;
    assign mem_addr    = req_addr_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;

    // Next-state and next-register computation.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        req_addr_nxt_s    = req_addr_r;
        instr_nxt_s       = instr_r;
        instr_pc_nxt_s    = instr_pc_r;
        instr_valid_nxt_s = instr_valid_r;
`ifdef FETCH_PREFETCH_EN
        buf_valid_nxt_s   = buf_valid_r;
        buf_data_nxt_s    = buf_data_r;
        buf_pc_nxt_s      = buf_pc_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // A redirect here only updates pc; the first fetch still uses the old pc.
                req_addr_nxt_s = pc_r;
                state_nxt_s    = ST_FETCH;
                if (redirect) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end

            ST_FETCH: begin
                if (redirect) begin
                    pc_nxt_s = redirect_pc;
                    if (mem_ack) begin
                        req_addr_nxt_s = redirect_pc;
                        state_nxt_s    = ST_FETCH;
                    end else begin
                        state_nxt_s    = ST_FLUSH;
                    end
                end else if (mem_ack) begin
                    instr_nxt_s       = mem_rdata;
                    instr_pc_nxt_s    = req_addr_r;
                    pc_nxt_s          = inc16(req_addr_r);
                    instr_valid_nxt_s = 1'b1;
                    state_nxt_s       = ST_HOLD;
`ifdef FETCH_PREFETCH_EN
                    req_addr_nxt_s    = inc16(req_addr_r);
`endif
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end

            ST_HOLD: begin
`ifdef FETCH_PREFETCH_EN
                if (redirect) begin
                    pc_nxt_s          = redirect_pc;
                    buf_valid_nxt_s   = 1'b0;
                    instr_valid_nxt_s = 1'b0;
                    if (mem_req_s && !mem_ack) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        req_addr_nxt_s = redirect_pc;
                        state_nxt_s    = ST_FETCH;
                    end
                end else if (instr_ready) begin
                    if (buf_valid_r) begin
                        instr_nxt_s     = buf_data_r;
                        instr_pc_nxt_s  = buf_pc_r;
                        buf_valid_nxt_s = 1'b0;
                    end else if (accept_s) begin
                        // Buffer fetch lands as the decoder consumes: bypass straight into instr.
                        instr_nxt_s    = mem_rdata;
                        instr_pc_nxt_s = req_addr_r;
                        pc_nxt_s       = inc16(req_addr_r);
                        req_addr_nxt_s = inc16(req_addr_r);
                    end else begin
                        instr_valid_nxt_s = 1'b0;
                        state_nxt_s       = ST_FETCH;
                    end
                end else if (accept_s) begin
                    buf_valid_nxt_s = 1'b1;
                    buf_data_nxt_s  = mem_rdata;
                    buf_pc_nxt_s    = req_addr_r;
                    pc_nxt_s        = inc16(req_addr_r);
                    req_addr_nxt_s  = inc16(req_addr_r);
                end else begin
                    state_nxt_s = ST_HOLD;
                end
`else
                if (redirect) begin
                    pc_nxt_s          = redirect_pc;
                    req_addr_nxt_s    = redirect_pc;
                    instr_valid_nxt_s = 1'b0;
                    state_nxt_s       = ST_FETCH;
                end else if (instr_ready) begin
                    req_addr_nxt_s    = pc_r;
                    instr_valid_nxt_s = 1'b0;
                    state_nxt_s       = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
`endif
            end

            ST_FLUSH: begin
                // The stale request must complete at its original address before refetching.
                if (mem_ack) begin
                    if (redirect) begin
                        pc_nxt_s       = redirect_pc;
                        req_addr_nxt_s = redirect_pc;
                    end else begin
                        req_addr_nxt_s = pc_r;
                    end
                    state_nxt_s = ST_FETCH;
                end else if (redirect) begin
                    pc_nxt_s    = redirect_pc;
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end

            default: begin
                state_nxt_s       = ST_IDLE;
                instr_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            req_addr_r    <= 16'h0000;
            instr_r       <= 16'h0000;
            instr_pc_r    <= 16'h0000;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            req_addr_r    <= req_addr_nxt_s;
            instr_r       <= instr_nxt_s;
            instr_pc_r    <= instr_pc_nxt_s;
            instr_valid_r <= instr_valid_nxt_s;
        end
    end

`ifdef FETCH_PREFETCH_EN
    // Prefetch buffer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= 16'h0000;
            buf_pc_r    <= 16'h0000;
        end else begin
            buf_valid_r <= buf_valid_nxt_s;
            buf_data_r  <= buf_data_nxt_s;
            buf_pc_r    <= buf_pc_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): reset, streaming, backpressure, wait states, redirects, PC wrap.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic        w_mem_req;
    logic [15:0] w_mem_addr;
    logic        w_mem_ack;
    logic [15:0] w_mem_rdata;
    logic [15:0] w_instr;
    logic [15:0] w_instr_pc;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic        w_redirect;
    logic [15:0] w_redirect_pc;

    int wait_cycles;
    int wcnt;
    int n_pass;
    int n_checks;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .reset(reset),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word = addr ^ A5A5, acknowledged after wait_cycles extra cycles.
    assign mem_ack     = mem_req && (wcnt == wait_cycles);
    assign mem_rdata   = mem_addr ^ 16'hA5A5;
    assign w_mem_ack   = w_mem_req;
    assign w_mem_rdata = w_mem_addr ^ 16'hA5A5;
    assign w_instr_ready = 1'b1;
    assign w_redirect    = 1'b0;
    assign w_redirect_pc = 16'h0000;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        wait_cycles = 0;
        reset = 1'b0;
        instr_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        step();
        step();
        chk("rst_mem_req",  {15'd0, mem_req}, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_instr",    instr, 16'h0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        chk("rst_valid",    {15'd0, instr_valid}, 16'h0000);
        chk("rst_w_addr",   w_mem_addr, 16'h0000);

        // Streaming, zero wait, decoder always ready
        reset = 1'b1;
        step();
        chk("first_req",    {15'd0, mem_req}, 16'h0001);
        chk("first_addr",   mem_addr, 16'h0000);
        chk("first_valid0", {15'd0, instr_valid}, 16'h0000);
        chk("wrap_addr0",   w_mem_addr, 16'hFFFF);
        step();
        chk("s0_valid", {15'd0, instr_valid}, 16'h0001);
        chk("s0_pc",    instr_pc, 16'h0000);
        chk("s0_instr", instr, 16'hA5A5);
        chk("wrap_pc0",    w_instr_pc, 16'hFFFF);
        chk("wrap_instr0", w_instr, 16'h5A5A);
        step();
        chk("s1_addr",  mem_addr, 16'h0001);
        chk("s1_gap",   {15'd0, instr_valid}, 16'h0000);
        chk("wrap_addr1", w_mem_addr, 16'h0000);
        step();
        chk("s1_pc",    instr_pc, 16'h0001);
        chk("s1_instr", instr, 16'hA5A4);
        chk("wrap_pc1",    w_instr_pc, 16'h0000);
        chk("wrap_instr1", w_instr, 16'hA5A5);
        step();
        step();
        chk("s2_valid", {15'd0, instr_valid}, 16'h0001);
        chk("s2_pc",    instr_pc, 16'h0002);
        chk("s2_instr", instr, 16'hA5A7);

        // Backpressure in HOLD
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_instr", instr, 16'hA5A7);
            chk("bp_pc",    instr_pc, 16'h0002);
            chk("bp_req",   {15'd0, mem_req}, 16'h0000);
            chk("bp_valid", {15'd0, instr_valid}, 16'h0001);
        end
        instr_ready = 1'b1;
        step();
        chk("bp_next_addr", mem_addr, 16'h0003);
        chk("bp_next_req",  {15'd0, mem_req}, 16'h0001);
        step();
        chk("bp_next_pc",    instr_pc, 16'h0003);
        chk("bp_next_instr", instr, 16'hA5A6);

        // Jump to 0x0010 and fetch it from 3-wait memory
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        wait_cycles = 3;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("w3_req",   {15'd0, mem_req}, 16'h0001);
            chk("w3_addr",  mem_addr, 16'h0010);
            chk("w3_valid", {15'd0, instr_valid}, 16'h0000);
            chk("w3_ack",   {15'd0, mem_ack}, (i == 3) ? 16'h0001 : 16'h0000);
            step();
        end
        chk("w3_valid_rise", {15'd0, instr_valid}, 16'h0001);
        chk("w3_pc",    instr_pc, 16'h0010);
        chk("w3_instr", instr, 16'hA5B5);

        // Redirect to 0x0200 while a 3-wait fetch of 0x0010 is outstanding
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        step();
        chk("fl_addr0", mem_addr, 16'h0010);
        redirect_pc = 16'h0200;
        step();
        redirect = 1'b0;
        chk("fl_keep_addr", mem_addr, 16'h0010);
        chk("fl_valid_a",   {15'd0, instr_valid}, 16'h0000);
        step();
        step();
        chk("fl_stale_ack", {15'd0, mem_ack}, 16'h0001);
        chk("fl_stale_addr", mem_addr, 16'h0010);
        step();
        wait_cycles = 0;
        chk("fl_discard", {15'd0, instr_valid}, 16'h0000);
        chk("fl_new_addr", mem_addr, 16'h0200);
        chk("fl_new_req",  {15'd0, mem_req}, 16'h0001);
        step();
        chk("fl_valid", {15'd0, instr_valid}, 16'h0001);
        chk("fl_pc",    instr_pc, 16'h0200);
        chk("fl_instr", instr, 16'hA7A5);

        // Redirect to 0x0040 together with instr_ready in HOLD
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("rh_drop",  {15'd0, instr_valid}, 16'h0000);
        chk("rh_addr",  mem_addr, 16'h0040);
        step();
        chk("rh_pc",    instr_pc, 16'h0040);
        chk("rh_instr", instr, 16'hA5E5);

        // Redirect in FETCH coinciding with a zero-wait ack
        step();
        chk("rf_addr0", mem_addr, 16'h0041);
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        step();
        redirect = 1'b0;
        chk("rf_addr",  mem_addr, 16'h0080);
        chk("rf_req",   {15'd0, mem_req}, 16'h0001);
        chk("rf_valid", {15'd0, instr_valid}, 16'h0000);
        step();
        chk("rf_pc",    instr_pc, 16'h0080);
        chk("rf_instr", instr, 16'hA525);

        // Reset asserted mid-fetch
        step();
        chk("mr_req_before", {15'd0, mem_req}, 16'h0001);
        reset = 1'b0;
        step();
        chk("mr_req",   {15'd0, mem_req}, 16'h0000);
        chk("mr_addr",  mem_addr, 16'h0000);
        chk("mr_valid", {15'd0, instr_valid}, 16'h0000);
        chk("mr_instr", instr, 16'h0000);
        chk("mr_pc",    instr_pc, 16'h0000);
        reset = 1'b1;
        step();
        chk("mr_refetch_addr", mem_addr, 16'h0000);
        chk("mr_refetch_req",  {15'd0, mem_req}, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
